// File: rtl/data_mem_waitstate.sv
// MEM-stage data memory with programmable wait states, word/byte access and
// address/alignment fault reporting. Accesses complete on the edge into DONE.
module data_mem_waitstate #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res,
  input  logic [31:0] Val_Rm,
  input  logic        mem_w_en,
  input  logic        mem_r_en,
  input  logic        byte_en,
  output logic [31:0] res_data,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         lane_q;
  logic [31:0]        wdata_q;
  logic               store_q, byte_q, fault_q;
  logic [31:0]        res_data_q;
  logic               mem_err_q;
  logic [31:0]        mem_q [DEPTH];

  logic               req;
  logic [31:0]        offset;
  logic               in_fault;
  logic               ready_fsm;
  logic               do_access;

  logic               use_live;
  logic [IDX_W-1:0]   acc_idx;
  logic [1:0]         acc_lane;
  logic [31:0]        acc_wdata;
  logic               acc_store, acc_byte, acc_fault;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;

  assign req      = mem_r_en | mem_w_en;
  assign offset   = alu_res - BASE_ADDR;
  assign in_fault = (alu_res < BASE_ADDR)
                  | (offset[31:2] >= 30'(DEPTH))
                  | (~byte_en & (offset[1:0] != 2'b00));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_fsm = 1'b1;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_fsm = ~req;
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d   = DONE;
            do_access = 1'b1;
          end
        end
      end
      BUSY: begin
        ready_fsm = 1'b0;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = DONE;
          do_access = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero wait states complete straight from IDLE, before the capture registers hold the request.
  assign use_live  = (state_q == IDLE);
  assign acc_idx   = use_live ? offset[IDX_W+1:2] : idx_q;
  assign acc_lane  = use_live ? offset[1:0]       : lane_q;
  assign acc_wdata = use_live ? Val_Rm            : wdata_q;
  assign acc_store = use_live ? mem_w_en          : store_q;
  assign acc_byte  = use_live ? byte_en           : byte_q;
  assign acc_fault = use_live ? in_fault          : fault_q;

  assign rd_word   = mem_q[acc_idx];
  assign rd_byte   = rd_word[{acc_lane, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'd0;
      store_q    <= 1'b0;
      byte_q     <= 1'b0;
      fault_q    <= 1'b0;
      res_data_q <= 32'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= do_access & acc_fault;
      if (state_q == IDLE && req) begin
        idx_q   <= offset[IDX_W+1:2];
        lane_q  <= offset[1:0];
        wdata_q <= Val_Rm;
        store_q <= mem_w_en;
        byte_q  <= byte_en;
        fault_q <= in_fault;
      end
      if (do_access && !acc_store) begin
        if (acc_fault)     res_data_q <= 32'd0;
        else if (acc_byte) res_data_q <= {24'd0, rd_byte};
        else               res_data_q <= rd_word;
      end
    end
  end

  // NOTE: the array is cleared by the async reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (do_access && acc_store && !acc_fault) begin
      if (acc_byte) mem_q[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_wdata[7:0];
      else          mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign mem_ready = ~rst | ready_fsm;
  assign res_data  = res_data_q;
  assign mem_err   = mem_err_q;

endmodule
